// File: rtl/knn_recompute_sched_if.sv
// Shared entry type and the query/datapath/result bundle of knn_recompute_sched.
// Signals: query handshake (q_valid/q_ready, qp_*, knn_in), issue handshake
// (dp_valid/dp_ready, dp_entry, dp_qp_*), result stream (res_valid, res_entry)
// and completion status (knn_out, done, max_dist, max_idx, err).
// Modports: master = environment side, slave = scheduler side.

`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif
`ifndef K
`define K 4
`endif

package knn_recompute_sched_pkg;
    localparam int unsigned BW     = `BIT_WIDTH;
    localparam int unsigned DIST_W = 2 * BW;
    localparam int unsigned ID_W   = 16;

    // One KNN list slot: valid flag, neighbour point id, squared distance.
    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic [DIST_W-1:0] distance;
    } knn_entry_t;
endpackage

interface knn_recompute_sched_if
    import knn_recompute_sched_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = `BIT_WIDTH,
    parameter int unsigned K         = `K
);
    logic                   q_valid;
    logic                   q_ready;
    logic [BIT_WIDTH-1:0]   qp_x;
    logic [BIT_WIDTH-1:0]   qp_y;
    logic [BIT_WIDTH-1:0]   qp_z;
    knn_entry_t [0:K-1]     knn_in;
    logic                   dp_valid;
    logic                   dp_ready;
    knn_entry_t             dp_entry;
    logic [BIT_WIDTH-1:0]   dp_qp_x;
    logic [BIT_WIDTH-1:0]   dp_qp_y;
    logic [BIT_WIDTH-1:0]   dp_qp_z;
    logic                   res_valid;
    knn_entry_t             res_entry;
    knn_entry_t [0:K-1]     knn_out;
    logic                   done;
    logic [2*BIT_WIDTH-1:0] max_dist;
    logic [$clog2(K)-1:0]   max_idx;
    logic                   err;

    modport master (
        output q_valid, qp_x, qp_y, qp_z, knn_in, dp_ready, res_valid, res_entry,
        input  q_ready, dp_valid, dp_entry, dp_qp_x, dp_qp_y, dp_qp_z,
               knn_out, done, max_dist, max_idx, err
    );

    modport slave (
        input  q_valid, qp_x, qp_y, qp_z, knn_in, dp_ready, res_valid, res_entry,
        output q_ready, dp_valid, dp_entry, dp_qp_x, dp_qp_y, dp_qp_z,
               knn_out, done, max_dist, max_idx, err
    );
endinterface

// File: rtl/knn_recompute_sched.sv
// Schedules recomputation of a K-entry KNN list for a new query point: issues
// each previous entry to a distance datapath, collects the in-order results
// into knn_out and tracks the largest valid distance and its index.
// Ports: clk, reset (synchronous, active-high), bus (slave side of
// knn_recompute_sched_if). K must be at least 2.

`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif
`ifndef K
`define K 4
`endif

module knn_recompute_sched
    import knn_recompute_sched_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = `BIT_WIDTH,
    parameter int unsigned K         = `K
) (
    input  logic                 clk,
    input  logic                 reset,
    knn_recompute_sched_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(K);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_issue_cnt;
    logic [CNT_W-1:0]     r_rsp_cnt;
    knn_entry_t           r_table [K];
    knn_entry_t [0:K-1]   r_knn_out;
    knn_entry_t           r_dp_entry;
    logic [BIT_WIDTH-1:0] r_qp_x;
    logic [BIT_WIDTH-1:0] r_qp_y;
    logic [BIT_WIDTH-1:0] r_qp_z;
    logic [DIST_W-1:0]    r_max_dist;
    logic [IDX_W-1:0]     r_max_idx;
    logic                 r_q_ready;
    logic                 r_dp_valid;
    logic                 r_done;
    logic                 r_err;

    logic [CNT_W-1:0]     w_outstanding;
    logic [IDX_W-1:0]     w_rsp_idx;
    logic [IDX_W-1:0]     w_next_idx;
    logic                 w_q_acc;
    logic                 w_iss_acc;
    logic                 w_res_ok;
    logic                 w_res_err;
    logic                 w_last_issue;
    logic                 w_last_rsp;
    logic                 w_max_upd;

    // Handshake and result-acceptance decode
    assign w_outstanding = r_issue_cnt - r_rsp_cnt;
    assign w_q_acc       = bus.q_valid && r_q_ready;
    assign w_iss_acc     = r_dp_valid && bus.dp_ready;
    assign w_res_ok      = bus.res_valid && (r_state == S_ISSUE || r_state == S_DRAIN)
                           && (w_outstanding != '0);
    assign w_res_err     = bus.res_valid && !w_res_ok;
    assign w_rsp_idx     = r_rsp_cnt[IDX_W-1:0];
    assign w_next_idx    = IDX_W'(r_issue_cnt + CNT_W'(1));
    assign w_last_issue  = (r_issue_cnt == CNT_W'(K - 1));
    assign w_last_rsp    = (r_rsp_cnt == CNT_W'(K - 1));
    // Strict compare keeps the lower index on ties; invalid results never win
    assign w_max_upd     = w_res_ok && bus.res_entry.valid
                           && (bus.res_entry.distance > r_max_dist);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the final result can only arrive once all K are issued
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_q_acc) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_iss_acc && w_last_issue) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_res_ok && w_last_rsp) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered status flags and issue/response counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q_ready   <= 1'b1;
            r_dp_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_issue_cnt <= '0;
            r_rsp_cnt   <= '0;
        end else begin
            r_q_ready  <= (w_state_nxt == S_IDLE);
            r_dp_valid <= (w_state_nxt == S_ISSUE);
            r_done     <= (w_state_nxt == S_DONE);
            if (w_res_err) begin
                r_err <= 1'b1;
            end
            if (w_q_acc) begin
                r_issue_cnt <= '0;
                r_rsp_cnt   <= '0;
            end else begin
                if (w_iss_acc) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
                if (w_res_ok)  r_rsp_cnt   <= r_rsp_cnt + CNT_W'(1);
            end
        end
    end

    // Captured previous list; only read while an operation is in flight
    always_ff @(posedge clk) begin
        if (w_q_acc) begin
            for (int unsigned i = 0; i < K; i++) begin
                r_table[i] <= bus.knn_in[i];
            end
        end
    end

    // Query capture, issue entry, result list and running max
    always_ff @(posedge clk) begin
        if (reset) begin
            r_qp_x     <= '0;
            r_qp_y     <= '0;
            r_qp_z     <= '0;
            r_dp_entry <= '0;
            r_knn_out  <= '0;
            r_max_dist <= '0;
            r_max_idx  <= '0;
        end else begin
            if (w_q_acc) begin
                r_qp_x     <= bus.qp_x;
                r_qp_y     <= bus.qp_y;
                r_qp_z     <= bus.qp_z;
                r_dp_entry <= bus.knn_in[0];
                r_max_dist <= '0;
                r_max_idx  <= '0;
            end else begin
                // Preload the next entry so dp_entry is a register output
                if (w_iss_acc && !w_last_issue) begin
                    r_dp_entry <= r_table[w_next_idx];
                end
                if (w_res_ok) begin
                    r_knn_out[w_rsp_idx] <= bus.res_entry;
                end
                if (w_max_upd) begin
                    r_max_dist <= bus.res_entry.distance;
                    r_max_idx  <= w_rsp_idx;
                end
            end
        end
    end

    assign bus.q_ready  = r_q_ready;
    assign bus.dp_valid = r_dp_valid;
    assign bus.dp_entry = r_dp_entry;
    assign bus.dp_qp_x  = r_qp_x;
    assign bus.dp_qp_y  = r_qp_y;
    assign bus.dp_qp_z  = r_qp_z;
    assign bus.knn_out  = r_knn_out;
    assign bus.done     = r_done;
    assign bus.max_dist = r_max_dist;
    assign bus.max_idx  = r_max_idx;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_knn_recompute_sched.sv
// Directed bench for knn_recompute_sched with K=4. A small datapath model
// returns issued entries two cycles after acceptance, replacing their
// valid/distance fields from a per-query table of expected results.

module tb_knn_recompute_sched;
    import knn_recompute_sched_pkg::*;

    localparam int unsigned TB_BW = 16;
    localparam int unsigned TB_K  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    knn_recompute_sched_if #(.BIT_WIDTH(TB_BW), .K(TB_K)) bus ();

    knn_recompute_sched #(.BIT_WIDTH(TB_BW), .K(TB_K)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Datapath model state
    bit                dp_en;
    bit                st1_v, st2_v;
    knn_entry_t        st1, st2;
    int                m_iss;
    logic [DIST_W-1:0] new_dist [4];
    logic              new_val  [4];
    int                iss_hist [4];
    bit                stall_mode;
    int                stall_left;
    bit                stalled;
    knn_entry_t        held;
    int                n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample issue before the edge, update model and dp_ready after it
    task automatic step();
        logic       iss;
        knn_entry_t e;
        iss = bus.dp_valid && bus.dp_ready;
        e   = bus.dp_entry;
        @(posedge clk);
        #1;
        if (iss) begin
            iss_hist[e.id[1:0]]++;
            if (m_iss < 4) begin
                e.valid    = new_val[m_iss];
                e.distance = new_dist[m_iss];
            end
            m_iss++;
        end
        if (dp_en) begin
            st2_v         = st1_v;
            st2           = st1;
            st1_v         = iss;
            st1           = iss ? e : '0;
            bus.res_valid = st2_v;
            bus.res_entry = st2;
        end
        if (stalled) begin
            chk("stall_dp_valid", 64'(bus.dp_valid), 64'd1);
            chk("stall_dp_entry", 64'(bus.dp_entry), 64'(held));
        end
        stalled      = 1'b0;
        bus.dp_ready = 1'b1;
        if (stall_mode && bus.dp_valid && bus.dp_entry.id == ID_W'(2) && stall_left > 0) begin
            bus.dp_ready = 1'b0;
            stall_left--;
            stalled = 1'b1;
            held    = bus.dp_entry;
        end
    endtask

    task automatic load_query(input logic [TB_BW-1:0] qx);
        bus.qp_x = qx;
        bus.qp_y = qx + TB_BW'(1);
        bus.qp_z = qx + TB_BW'(2);
        for (int i = 0; i < 4; i++) begin
            bus.knn_in[i] = '{valid: 1'b1, id: ID_W'(i), distance: DIST_W'(1000 + i)};
            iss_hist[i]   = 0;
        end
        m_iss = 0;
    endtask

    task automatic set_dists(input int d0, input int d1, input int d2, input int d3,
                             input logic v3);
        new_dist[0] = DIST_W'(d0);
        new_dist[1] = DIST_W'(d1);
        new_dist[2] = DIST_W'(d2);
        new_dist[3] = DIST_W'(d3);
        new_val[0]  = 1'b1;
        new_val[1]  = 1'b1;
        new_val[2]  = 1'b1;
        new_val[3]  = v3;
    endtask

    // Steps until done is seen; cnt = edges after the accept edge
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (bus.done !== 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        chk("done_seen", 64'(bus.done), 64'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_q_ready"},  64'(bus.q_ready),  64'd1);
        chk({tag, "_dp_valid"}, 64'(bus.dp_valid), 64'd0);
        chk({tag, "_done"},     64'(bus.done),     64'd0);
        chk({tag, "_err"},      64'(bus.err),      64'd0);
        chk({tag, "_max_dist"}, 64'(bus.max_dist), 64'd0);
        chk({tag, "_max_idx"},  64'(bus.max_idx),  64'd0);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_knn_out"}, 64'(bus.knn_out[i]), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.q_valid   = 1'b0;
        bus.qp_x      = '0;
        bus.qp_y      = '0;
        bus.qp_z      = '0;
        bus.knn_in    = '0;
        bus.dp_ready  = 1'b1;
        bus.res_valid = 1'b0;
        bus.res_entry = '0;
        dp_en = 1'b1; st1_v = 1'b0; st2_v = 1'b0; st1 = '0; st2 = '0;
        stall_mode = 1'b0; stall_left = 0; stalled = 1'b0; held = '0; m_iss = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reset_state("rst");

        // Basic run: distances {5,9,3,9}, tie at index 3 keeps index 1
        load_query(16'h0011);
        set_dists(5, 9, 3, 9, 1'b1);
        bus.q_valid = 1'b1;
        step();
        bus.q_valid = 1'b0;
        chk("acc_q_ready",  64'(bus.q_ready),           64'd0);
        chk("acc_dp_valid", 64'(bus.dp_valid),          64'd1);
        chk("acc_qp_x",     64'(bus.dp_qp_x),           64'h11);
        chk("acc_qp_z",     64'(bus.dp_qp_z),           64'h13);
        chk("acc_entry0",   64'(bus.dp_entry.distance), 64'd1000);
        wait_done(n);
        chk("basic_latency", 64'(n), 64'd6);
        chk("basic_max_dist", 64'(bus.max_dist), 64'd9);
        chk("basic_max_idx",  64'(bus.max_idx),  64'd1);
        chk("basic_out1",     64'(bus.knn_out[1].distance), 64'd9);
        chk("basic_out3",     64'(bus.knn_out[3].distance), 64'd9);
        chk("basic_out2_id",  64'(bus.knn_out[2].id), 64'd2);
        chk("basic_err",      64'(bus.err), 64'd0);
        step();
        chk("basic_done_pulse", 64'(bus.done),     64'd0);
        chk("basic_idle_ready", 64'(bus.q_ready),  64'd1);
        chk("basic_max_hold",   64'(bus.max_dist), 64'd9);

        // dp_ready held low three cycles on entry 2
        stall_mode = 1'b1;
        stall_left = 3;
        load_query(16'h0022);
        set_dists(4, 2, 8, 1, 1'b1);
        bus.q_valid = 1'b1;
        step();
        bus.q_valid = 1'b0;
        wait_done(n);
        stall_mode = 1'b0;
        chk("stall_latency", 64'(n), 64'd9);
        for (int i = 0; i < 4; i++) begin
            chk("stall_issue_once", 64'(iss_hist[i]), 64'd1);
            chk("stall_order_id",   64'(bus.knn_out[i].id), 64'(i));
        end
        chk("stall_out0", 64'(bus.knn_out[0].distance), 64'd4);
        chk("stall_out2", 64'(bus.knn_out[2].distance), 64'd8);
        chk("stall_out3", 64'(bus.knn_out[3].distance), 64'd1);
        chk("stall_max_dist", 64'(bus.max_dist), 64'd8);
        chk("stall_max_idx",  64'(bus.max_idx),  64'd2);
        step();

        // Invalid result with a large distance is excluded from the max
        load_query(16'h0033);
        set_dists(1, 2, 3, 100, 1'b0);
        bus.q_valid = 1'b1;
        step();
        bus.q_valid = 1'b0;
        wait_done(n);
        chk("inv_max_dist", 64'(bus.max_dist), 64'd3);
        chk("inv_max_idx",  64'(bus.max_idx),  64'd2);
        chk("inv_out3_dist",  64'(bus.knn_out[3].distance), 64'd100);
        chk("inv_out3_valid", 64'(bus.knn_out[3].valid), 64'd0);
        step();

        // Stray result in IDLE: sticky error, list untouched
        dp_en = 1'b0;
        bus.res_valid = 1'b1;
        bus.res_entry = '{valid: 1'b1, id: ID_W'(16'h55), distance: DIST_W'(77)};
        step();
        bus.res_valid = 1'b0;
        bus.res_entry = '0;
        dp_en = 1'b1;
        chk("stray_err",      64'(bus.err), 64'd1);
        chk("stray_out0",     64'(bus.knn_out[0].distance), 64'd1);
        chk("stray_out0_id",  64'(bus.knn_out[0].id), 64'd0);
        chk("stray_max",      64'(bus.max_dist), 64'd3);
        load_query(16'h0044);
        set_dists(6, 6, 6, 6, 1'b1);
        bus.q_valid = 1'b1;
        step();
        bus.q_valid = 1'b0;
        wait_done(n);
        chk("stray_err_sticky", 64'(bus.err),      64'd1);
        chk("tie_max_dist",     64'(bus.max_dist), 64'd6);
        chk("tie_max_idx",      64'(bus.max_idx),  64'd0);
        step();

        // Reset after two issues aborts; the next query runs normally
        load_query(16'h0055);
        set_dists(8, 8, 8, 8, 1'b1);
        bus.q_valid = 1'b1;
        step();
        bus.q_valid = 1'b0;
        step();
        step();
        chk("abort_two_issued", 64'(bus.dp_entry.id), 64'd2);
        reset = 1'b1;
        dp_en = 1'b0;
        bus.res_valid = 1'b0;
        step();
        reset = 1'b0;
        st1_v = 1'b0; st2_v = 1'b0; st1 = '0; st2 = '0;
        dp_en = 1'b1;
        chk_reset_state("abort");
        load_query(16'h0066);
        set_dists(7, 1, 7, 2, 1'b1);
        bus.q_valid = 1'b1;
        step();
        bus.q_valid = 1'b0;
        wait_done(n);
        chk("post_abort_latency", 64'(n), 64'd6);
        chk("post_abort_max",     64'(bus.max_dist), 64'd7);
        chk("post_abort_idx",     64'(bus.max_idx),  64'd0);
        chk("post_abort_out3",    64'(bus.knn_out[3].distance), 64'd2);
        chk("post_abort_err",     64'(bus.err), 64'd0);
        step();

        // q_valid held through a busy operation
        load_query(16'h0077);
        set_dists(3, 4, 5, 6, 1'b1);
        bus.q_valid = 1'b1;
        step();
        bus.qp_x = 16'h0088;
        bus.qp_y = 16'h0089;
        bus.qp_z = 16'h008a;
        wait_done(n);
        chk("held_latency",  64'(n), 64'd6);
        chk("held_busy_qp",  64'(bus.dp_qp_x), 64'h77);
        chk("held_max_dist", 64'(bus.max_dist), 64'd6);
        chk("held_max_idx",  64'(bus.max_idx),  64'd3);
        step();
        chk("held_idle_ready", 64'(bus.q_ready),  64'd1);
        chk("held_idle_qp",    64'(bus.dp_qp_x),  64'h77);
        chk("held_idle_max",   64'(bus.max_dist), 64'd6);
        m_iss = 0;
        for (int i = 0; i < 4; i++) iss_hist[i] = 0;
        set_dists(9, 1, 1, 1, 1'b1);
        step();
        bus.q_valid = 1'b0;
        chk("held_accept_ready", 64'(bus.q_ready),  64'd0);
        chk("held_accept_valid", 64'(bus.dp_valid), 64'd1);
        chk("held_accept_qp",    64'(bus.dp_qp_x),  64'h88);
        wait_done(n);
        chk("held2_latency", 64'(n), 64'd6);
        chk("held2_max",     64'(bus.max_dist), 64'd9);
        chk("held2_idx",     64'(bus.max_idx),  64'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
